axby_arb: RTL and testbench
===========================

# axby_arb

Two-port arbiter and handshake controller that shares one AXBY compute unit (sequencer plus datapath) between two requesters. It accepts operand pairs, issues the unit's level START/RDY handshake, returns the result to the owning requester under a done/ack handshake, and aborts on a watchdog timeout. It sits between the client logic and the AXBY unit's START/RDY/operand/result pins.

## Interface

- W, 8, operand width (x, y)
- RW, 16, result width (2*W)
- TIMEOUT, 64, max cycles in BUSY waiting for RDY before abort; legal range 2..255

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0, req1  in  1  level request from requester 0 / 1
- x0, y0, x1, y1  in  W  operands of requester 0 / 1, sampled at grant
- gnt0, gnt1  out  1  one-cycle grant pulse; operands captured on this edge
- done0, done1  out  1  result valid for owner, held until ack
- ack0, ack1  in  1  owner consumes result
- rez_out  out  RW  result (or 0 on timeout), stable while done is high
- err  out  1  timeout flag, valid with done
- busy  out  1  high in BUSY and DONE
- START  out  1  level start to AXBY unit
- X, Y  out  W  operands to AXBY unit, stable while START high
- RDY  in  1  unit completion (SETRDYP)
- REZ  in  RW  unit result

## Operation

- All outputs registered. Reset (async): state IDLE, START=0, X=Y=0, rez_out=0, gnt*=0, done*=0, err=0, busy=0, last-served pointer lp=1 (requester 0 wins first tie), owner=0, timer=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any req sampled high → pick winner: only one requesting → that one; both → the one != lp. On that edge: gnt_winner=1 (one cycle), X/Y ← winner's operands, START=1, owner ← winner, lp ← winner, timer ← 0, go BUSY. No req → stay.
- BUSY: START held 1, X/Y held. Each edge: RDY=1 → START=0, rez_out ← REZ, err=0, done_owner=1, go DONE. Else if timer == TIMEOUT-1 → START=0, rez_out=0, err=1, done_owner=1, go DONE. Else timer+1. RDY and timeout on same edge: RDY wins.
- DONE: done_owner and rez_out/err held. ack_owner sampled high → done=0, err=0, go IDLE. ack of non-owner ignored. req of either port ignored (no grant) until IDLE.
- A requester still holding req after its ack is treated as a new request and arbitrated normally (round-robin prevents starvation).
- gnt is never asserted outside the IDLE→BUSY edge; at most one of gnt0/gnt1, done0/done1 high at any time.
- Reset mid-operation: START drops immediately; no done is produced for the aborted op.

## Timing

- Grant latency: req sampled at edge N (IDLE) → gnt, START, X/Y valid in cycle N+1.
- START stays high through the edge that samples RDY=1; falls the following cycle together with done rising.
- Result latency: done rises the cycle after RDY is sampled high.
- START low for ≥2 cycles between operations (≥1 DONE cycle + 1 IDLE cycle), letting the unit return from its wait state to idle before the next START.
- Timeout: with RDY stuck 0, done/err rise TIMEOUT cycles after gnt.
- Ack: done falls the cycle after ack sampled; next grant earliest one cycle later.
- Back-to-back throughput: unit latency + 3 cycles per operation with ack returned immediately.

## Test plan

- Single request: req0=1, x0=3, y0=5, model RDY after 20 cycles with REZ=0x0022 → gnt0 one cycle with X=3,Y=5,START=1; done0=1, rez_out=0x0022, err=0; ack0 → done0=0, IDLE.
- Tie round-robin: req0=req1=1 held, ack each done → grants alternate 0,1,0,1 starting with 0 after reset; operands on X/Y match the granted port.
- Timeout: TIMEOUT=8, RDY held 0 → START falls, done=1, err=1, rez_out=0 exactly 8 cycles after gnt; ack clears err.
- RDY on timeout edge: RDY=1 on cycle TIMEOUT-1 of BUSY, REZ=0x1234 → err=0, rez_out=0x1234.
- Wrong-port ack and late req: in DONE for owner 0, pulse ack1 and raise req1 → done0 stays high, no gnt1; ack0 → next cycle IDLE, gnt1 one cycle later.
- Reset mid-BUSY: assert rst with START=1 → START, busy, done all 0 immediately; after release req1 alone is granted normally, tie then goes to requester 0.

Source files
------------

// File: rtl/axby_arb.sv
// Two-port round-robin arbiter sharing one AXBY unit; drives the unit's
// level START/RDY handshake and returns results under a done/ack handshake.
module axby_arb #(
    parameter int W       = 8,
    parameter int RW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req0_i,
    input  logic          req1_i,
    input  logic [W-1:0]  x0_i,
    input  logic [W-1:0]  y0_i,
    input  logic [W-1:0]  x1_i,
    input  logic [W-1:0]  y1_i,
    output logic          gnt0_o,
    output logic          gnt1_o,
    output logic          done0_o,
    output logic          done1_o,
    input  logic          ack0_i,
    input  logic          ack1_i,
    output logic [RW-1:0] rez_out_o,
    output logic          err_o,
    output logic          busy_o,
    output logic          start_o,
    output logic [W-1:0]  x_o,
    output logic [W-1:0]  y_o,
    input  logic          rdy_i,
    input  logic [RW-1:0] rez_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic            start_q, start_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            owner_q, owner_d;
    logic            lp_q, lp_d;
    logic [7:0]      timer_q, timer_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [RW-1:0]   rez_q, rez_d;

    logic any_req;
    logic win;
    logic ack_own;
    logic tmo;

    // On a tie the requester that was not served last wins.
    assign any_req = req0_i | req1_i;
    assign win     = (req0_i & req1_i) ? ~lp_q : req1_i;
    assign ack_own = owner_q ? ack1_i : ack0_i;
    assign tmo     = (timer_q == TMO_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
            lp_q    <= 1'b1;
            timer_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            rez_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            start_q <= start_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            lp_q    <= lp_d;
            timer_q <= timer_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rez_q   <= rez_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (any_req) state_d = S_BUSY;
            S_BUSY:  if (rdy_i || tmo) state_d = S_DONE;
            S_DONE:  if (ack_own) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = done0_q;
        done1_d = done1_q;
        start_d = start_q;
        err_d   = err_q;
        owner_d = owner_q;
        lp_d    = lp_q;
        timer_d = timer_q;
        x_d     = x_q;
        y_d     = y_q;
        rez_d   = rez_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    x_d     = win ? x1_i : x0_i;
                    y_d     = win ? y1_i : y0_i;
                    start_d = 1'b1;
                    owner_d = win;
                    lp_d    = win;
                    timer_d = '0;
                end
            end
            S_BUSY: begin
                // RDY takes priority over a timeout on the same edge.
                if (rdy_i) begin
                    start_d = 1'b0;
                    rez_d   = rez_i;
                    err_d   = 1'b0;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                end else if (tmo) begin
                    start_d = 1'b0;
                    rez_d   = '0;
                    err_d   = 1'b1;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DONE: begin
                if (ack_own) begin
                    done0_d = 1'b0;
                    done1_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign gnt0_o    = gnt0_q;
    assign gnt1_o    = gnt1_q;
    assign done0_o   = done0_q;
    assign done1_o   = done1_q;
    assign start_o   = start_q;
    assign err_o     = err_q;
    assign busy_o    = busy_q;
    assign x_o       = x_q;
    assign y_o       = y_q;
    assign rez_out_o = rez_q;

endmodule

// File: tb/tb_axby_arb.sv
// Bench for axby_arb: directed vector table, corner sequences and a
// random phase checked against a transaction-level arbiter model.
module tb_axby_arb;

    localparam int W   = 8;
    localparam int RW  = 16;
    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req0, req1, ack0, ack1, rdy;
    logic [W-1:0]  x0, y0, x1, y1;
    logic [RW-1:0] rez_in;
    logic          gnt0, gnt1, done0, done1, err, busy, start;
    logic [W-1:0]  xo, yo;
    logic [RW-1:0] rez_out;

    axby_arb #(.W(W), .RW(RW), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .req1_i(req1),
        .x0_i(x0), .y0_i(y0), .x1_i(x1), .y1_i(y1),
        .gnt0_o(gnt0), .gnt1_o(gnt1),
        .done0_o(done0), .done1_o(done1),
        .ack0_i(ack0), .ack1_i(ack1),
        .rez_out_o(rez_out), .err_o(err), .busy_o(busy),
        .start_o(start), .x_o(xo), .y_o(yo),
        .rdy_i(rdy), .rez_i(rez_in)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    // Result the bench's AXBY unit produces for a given operand pair.
    function automatic logic [RW-1:0] f(input logic [W-1:0] a,
                                        input logic [W-1:0] b);
        logic [RW-1:0] p;
        p = {8'd0, a} * {8'd0, b};
        return p + 16'd19;
    endfunction

    function automatic logic [6:0] ctl();
        return {gnt0, gnt1, done0, done1, start, busy, err};
    endfunction

    // Transaction-level model: one outstanding op at a time.
    bit            m_on = 0, unit_on = 0;
    bit            m_out = 0, m_own = 0, m_lp = 1, m_err = 0;
    int            m_done_at = 0;
    logic [W-1:0]  m_x, m_y;
    logic [RW-1:0] m_rez;
    int            force_lat = 0;
    int            unit_lat = 1, unit_cnt = 0;
    int            gq[$];

    task automatic model_step();
        bit g, w;
        logic [6:0] e;
        g = 0;
        w = 0;
        if (!m_out && (req0 || req1)) begin
            w = (req0 && req1) ? !m_lp : req1;
            g = 1;
            m_out = 1;
            m_own = w;
            m_lp = w;
            m_x = w ? x1 : x0;
            m_y = w ? y1 : y0;
            unit_lat = (force_lat > 0) ? force_lat
                                       : int'($urandom_range(1, TMO + 3));
            if (unit_lat <= TMO) begin
                m_done_at = cyc + unit_lat;
                m_rez = f(m_x, m_y);
                m_err = 0;
            end else begin
                m_done_at = cyc + TMO;
                m_rez = '0;
                m_err = 1;
            end
        end else if (m_out && cyc - 1 >= m_done_at
                     && (m_own ? ack1 : ack0)) begin
            m_out = 0;
        end
        e = {g && !w, g && w,
             m_out && cyc >= m_done_at && !m_own,
             m_out && cyc >= m_done_at && m_own,
             m_out && cyc < m_done_at,
             m_out,
             m_out && cyc >= m_done_at && m_err};
        chk("ctl", 32'(ctl()), 32'(e));
        if (g) gq.push_back(int'(w));
        if (m_out && cyc < m_done_at) begin
            chk("x", 32'(xo), 32'(m_x));
            chk("y", 32'(yo), 32'(m_y));
        end
        if (m_out && cyc >= m_done_at) chk("rez", 32'(rez_out), 32'(m_rez));
    endtask

    task automatic unit_step();
        if (start) begin
            unit_cnt++;
            rdy = (unit_cnt == unit_lat);
            rez_in = f(xo, yo);
        end else begin
            unit_cnt = 0;
            rdy = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (m_on) model_step();
        if (unit_on) unit_step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = 0; req1 = 0; ack0 = 0; ack1 = 0; rdy = 0;
        unit_cnt = 0;
        m_out = 0;
        m_lp = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_done(input bit p);
        int n;
        n = 0;
        while (!(p ? done1 : done0) && n < 30) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(p ? done1 : done0), 32'd1);
    endtask

    typedef struct {
        logic r0, r1;
        logic [W-1:0] x0, y0, x1, y1;
        logic a0, a1, rdy;
        logic [RW-1:0] rez;
        logic [6:0] ctl;
        logic [W-1:0] ex, ey;
        logic [RW-1:0] erez;
    } vec_t;

    function automatic vec_t mk(
        input logic r0, r1, input logic [W-1:0] vx0, vy0, vx1, vy1,
        input logic a0, a1, r, input logic [RW-1:0] rz,
        input logic [6:0] c, input logic [W-1:0] ex, ey,
        input logic [RW-1:0] er);
        vec_t v;
        v.r0 = r0; v.r1 = r1;
        v.x0 = vx0; v.y0 = vy0; v.x1 = vx1; v.y1 = vy1;
        v.a0 = a0; v.a1 = a1; v.rdy = r; v.rez = rz;
        v.ctl = c; v.ex = ex; v.ey = ey; v.erez = er;
        return v;
    endfunction

    vec_t tbl[$];
    int   exp_rr[4] = '{0, 1, 0, 1};
    int   gc;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ctl = {gnt0,gnt1,done0,done1,start,busy,err}
        tbl.push_back(mk(1,0, 3,5,0,0, 0,0,0,16'h0,      7'b0000000, 0,0, 0));
        tbl.push_back(mk(0,0, 3,5,0,0, 0,0,0,16'h0,      7'b1000110, 3,5, 0));
        tbl.push_back(mk(0,0, 3,5,0,0, 0,0,0,16'h0,      7'b0000110, 3,5, 0));
        tbl.push_back(mk(0,0, 3,5,0,0, 0,0,1,16'h0022,   7'b0000110, 3,5, 0));
        tbl.push_back(mk(0,1, 3,5,7,9, 0,1,0,16'h0,      7'b0010010, 0,0, 16'h0022));
        tbl.push_back(mk(0,1, 3,5,7,9, 1,0,0,16'h0,      7'b0010010, 0,0, 16'h0022));
        tbl.push_back(mk(0,1, 3,5,7,9, 0,0,0,16'h0,      7'b0000000, 0,0, 0));
        tbl.push_back(mk(0,0, 3,5,7,9, 0,0,0,16'h0,      7'b0100110, 7,9, 0));
        tbl.push_back(mk(0,0, 3,5,7,9, 0,0,1,16'hBEEF,   7'b0000110, 7,9, 0));
        tbl.push_back(mk(0,0, 3,5,7,9, 0,1,0,16'h0,      7'b0001010, 0,0, 16'hBEEF));
        tbl.push_back(mk(0,0, 3,5,7,9, 0,0,0,16'h0,      7'b0000000, 0,0, 0));
        tbl.push_back(mk(0,0, 3,5,7,9, 0,0,0,16'h0,      7'b0000000, 0,0, 0));

        rst = 1'b1;
        req0 = 0; req1 = 0; ack0 = 0; ack1 = 0; rdy = 0;
        x0 = 0; y0 = 0; x1 = 0; y1 = 0; rez_in = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_ctl", 32'(ctl()), 32'd0);
        chk("reset_x", 32'(xo), 32'd0);
        chk("reset_y", 32'(yo), 32'd0);
        chk("reset_rez", 32'(rez_out), 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            if (i > 0) tick();
            chk("tbl_ctl", 32'(ctl()), 32'(tbl[i].ctl));
            if (tbl[i].ctl[2]) begin
                chk("tbl_x", 32'(xo), 32'(tbl[i].ex));
                chk("tbl_y", 32'(yo), 32'(tbl[i].ey));
            end
            if (tbl[i].ctl[4] || tbl[i].ctl[3])
                chk("tbl_rez", 32'(rez_out), 32'(tbl[i].erez));
            req0 = tbl[i].r0; req1 = tbl[i].r1;
            x0 = tbl[i].x0; y0 = tbl[i].y0;
            x1 = tbl[i].x1; y1 = tbl[i].y1;
            ack0 = tbl[i].a0; ack1 = tbl[i].a1;
            rdy = tbl[i].rdy; rez_in = tbl[i].rez;
        end

        do_reset();
        m_on = 1;
        unit_on = 1;

        // Single request through the unit model.
        force_lat = 6;
        req0 = 1; x0 = 3; y0 = 5;
        tick();
        req0 = 0;
        wait_done(0);
        chk("single_rez", 32'(rez_out), 32'h0022);
        chk("single_err", 32'(err), 32'd0);
        ack0 = 1;
        tick();
        ack0 = 0;
        chk("single_idle", 32'({done0, busy}), 32'd0);
        tick();

        // Tie arbitration alternates starting with requester 0.
        do_reset();
        gq.delete();
        force_lat = 3;
        x0 = 11; y0 = 12; x1 = 21; y1 = 22;
        req0 = 1; req1 = 1; ack0 = 1; ack1 = 1;
        for (int n = 0; n < 60 && gq.size() < 4; n++) tick();
        req0 = 0; req1 = 0;
        chk("rr_count", 32'(gq.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++)
            if (i < gq.size()) chk("rr_order", 32'(gq[i]), 32'(exp_rr[i]));
        for (int n = 0; n < 15; n++) tick();
        ack0 = 0; ack1 = 0;
        tick();

        // Watchdog timeout with RDY stuck low.
        force_lat = 100;
        req0 = 1; x0 = 40; y0 = 41;
        tick();
        gc = cyc;
        chk("tmo_gnt", 32'(gnt0), 32'd1);
        req0 = 0;
        wait_done(0);
        chk("tmo_lat", 32'(cyc - gc), 32'(TMO));
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_rez", 32'(rez_out), 32'd0);
        chk("tmo_start", 32'(start), 32'd0);
        ack0 = 1;
        tick();
        ack0 = 0;
        chk("tmo_err_clr", 32'(err), 32'd0);
        tick();

        // RDY arriving on the timeout edge wins.
        force_lat = TMO;
        req1 = 1; x1 = 51; y1 = 91;
        tick();
        req1 = 0;
        wait_done(1);
        chk("edge_err", 32'(err), 32'd0);
        chk("edge_rez", 32'(rez_out), 32'h1234);
        ack1 = 1;
        tick();
        ack1 = 0;
        tick();

        // Reset while BUSY.
        force_lat = 100;
        req1 = 1;
        tick();
        req1 = 0;
        tick();
        tick();
        chk("pre_rst_start", 32'(start), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async",
            32'({start, busy, done0, done1}), 32'd0);
        do_reset();
        force_lat = 2;
        req1 = 1;
        tick();
        req1 = 0;
        chk("rst_gnt1", 32'({gnt1, gnt0}), 32'b10);
        ack1 = 1;
        wait_done(1);
        tick();
        ack1 = 0;
        req0 = 1; req1 = 1;
        tick();
        req0 = 0; req1 = 0;
        chk("rst_tie_gnt0", 32'({gnt1, gnt0}), 32'b01);
        ack0 = 1;
        wait_done(0);
        tick();
        ack0 = 0;
        tick();

        // Random traffic against the model.
        force_lat = 0;
        for (int n = 0; n < 400; n++) begin
            req0 = 1'($urandom_range(0, 1));
            req1 = 1'($urandom_range(0, 1));
            x0 = 8'($urandom); y0 = 8'($urandom);
            x1 = 8'($urandom); y1 = 8'($urandom);
            ack0 = ($urandom_range(0, 2) == 0);
            ack1 = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
